seq_pattern_detector: RTL and testbench

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

---
 rtl/seq_pattern_detector.sv | 60 ++++++
 tb/tb_seq_pattern_detector.sv | 114 +++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: serial bit-pattern matcher with a loadable pattern, overlap control and a saturating match counter.
module seq_pattern_detector #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W = 8,
  parameter logic [PAT_LEN-1:0] PAT_RESET = PAT_LEN'(4'b1011)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din_valid,
  input  logic               din,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               overlap_en,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  typedef enum logic {FILL, HUNT} state_t;
  state_t             state_q, state_d;
  logic [PAT_LEN-1:0] pat_q, hist_q, hist_d, hist_sh;
  logic [FW-1:0]      fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc, hit, match_q, armed_q;
  always_comb begin
    acc      = din_valid & ~pat_load;
    hist_sh  = {hist_q[PAT_LEN-2:0], din};
    fill_inc = (fill_q == FULL) ? FULL : fill_q + FW'(1);
    hit      = acc && (hist_sh == pat_q) && (fill_inc == FULL);
    hist_d   = pat_load ? '0 : acc ? hist_sh : hist_q;
    // A non-overlapping match restarts the fill so the next match needs a full fresh pattern.
    fill_d   = pat_load ? '0 : !acc ? fill_q : (hit && !overlap_en) ? '0 : fill_inc;
    state_d  = (fill_d == FULL) ? HUNT : FILL;
    cnt_d    = cnt_clr ? '0 : (hit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q   <= PAT_RESET;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= FILL;
      match_q <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      if (pat_load) pat_q <= pat_in;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      match_q <= hit;
      cnt_q   <= cnt_d;
      armed_q <= (state_d == HUNT);
    end
  end
  assign match       = match_q;
  assign match_count = cnt_q;
  assign armed       = armed_q;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed checks of matching, overlap, pattern load, idle gaps, saturation and reset.
module tb_seq_pattern_detector;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din_valid = 1'b0, din = 1'b0, pat_load = 1'b0, overlap_en = 1'b1, cnt_clr = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       match_a, armed_a, match_b, armed_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  int         n_cmp = 0, n_err = 0;

  seq_pattern_detector dut_a (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pat_in(pat_in), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .match(match_a), .match_count(cnt_a), .armed(armed_a)
  );
  seq_pattern_detector #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pat_in(pat_in), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .match(match_b), .match_count(cnt_b), .armed(armed_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_match", 32'(match_a), 0);
    chk("rst_armed", 32'(armed_a), 0);
    chk("rst_count", 32'(cnt_a), 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send(input string tag, input logic d, input logic em, input logic ea);
    din_valid = 1'b1; din = d;
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk({tag, "_match"}, 32'(match_a), 32'(em));
    chk({tag, "_armed"}, 32'(armed_a), 32'(ea));
  endtask

  task automatic idle(input string tag, input logic d);
    din_valid = 1'b0; din = d;
    @(posedge clk); #1;
    chk({tag, "_idle_match"}, 32'(match_a), 0);
  endtask

  task automatic load(input logic [3:0] p);
    pat_load = 1'b1; pat_in = p; din_valid = 1'b1; din = 1'b1;
    @(posedge clk); #1;
    pat_load = 1'b0; din_valid = 1'b0;
    chk("load_match", 32'(match_a), 0);
    chk("load_armed", 32'(armed_a), 0);
  endtask

  initial begin
    do_reset();
    // overlapping: 1,0,1,1,0,1,1
    overlap_en = 1'b1;
    send("ov1", 1, 0, 0); send("ov2", 0, 0, 0); send("ov3", 1, 0, 0); send("ov4", 1, 1, 1);
    send("ov5", 0, 0, 1); send("ov6", 1, 0, 1); send("ov7", 1, 1, 1);
    chk("ov_count", 32'(cnt_a), 2);
    // non-overlapping: same stream
    do_reset();
    overlap_en = 1'b0;
    send("no1", 1, 0, 0); send("no2", 0, 0, 0); send("no3", 1, 0, 0); send("no4", 1, 1, 0);
    send("no5", 0, 0, 0); send("no6", 1, 0, 0); send("no7", 1, 0, 0);
    chk("no_count", 32'(cnt_a), 1);
    // pattern load after two accepted bits
    do_reset();
    overlap_en = 1'b1;
    send("pl1", 1, 0, 0); send("pl2", 1, 0, 0);
    load(4'b1111);
    send("pl3", 1, 0, 0); send("pl4", 1, 0, 0); send("pl5", 1, 0, 0); send("pl6", 1, 1, 1);
    send("pl7", 1, 1, 1);
    chk("pl_count", 32'(cnt_a), 2);
    // idle gaps with toggling din
    do_reset();
    send("ig1", 1, 0, 0); idle("ig1", 0); idle("ig1b", 1);
    send("ig2", 0, 0, 0); idle("ig2", 1);
    send("ig3", 1, 0, 0); idle("ig3", 0);
    send("ig4", 1, 1, 1); idle("ig4", 0);
    chk("ig_count", 32'(cnt_a), 1);
    // saturation on the narrow counter, then clear coincident with a match
    do_reset();
    load(4'b1111);
    for (int i = 0; i < 7; i++) send("sat", 1, i >= 3, i >= 3);
    chk("sat_count_a", 32'(cnt_a), 4);
    chk("sat_count_b", 32'(cnt_b), 3);
    chk("sat_match_b", 32'(match_b), 1);
    cnt_clr = 1'b1;
    send("clr", 1, 1, 1);
    cnt_clr = 1'b0;
    chk("clr_count_a", 32'(cnt_a), 0);
    chk("clr_count_b", 32'(cnt_b), 0);
    // reset mid-sequence discards history
    do_reset();
    send("mr1", 1, 0, 0); send("mr2", 0, 0, 0); send("mr3", 1, 0, 0);
    do_reset();
    send("mr4", 1, 0, 0);
    chk("mr_count", 32'(cnt_a), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
